// File: rtl/flag_sequencer.sv
// flag_sequencer: picks the flag index shown by the VGA pride display, stepping on frame boundaries only.
// Optional feature: define FLAG_SEQ_SHUFFLE_EN to make auto steps jump by a pseudo-random 1..8 (LFSR driven).
module flag_sequencer #(
    parameter int HOLD_FRAMES     = 180,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start_i,
    input  logic       btn_next_i,
    input  logic       btn_prev_i,
    input  logic       btn_mode_i,
    input  logic [7:0] count_i,
    output logic [7:0] selector_o,
    output logic       auto_mode_o,
    output logic       changed_o
);
    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int DW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_FRAMES - 1);

    // button vectors are ordered {mode, prev, next}
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    samp_q, deb_q, deb_d, pend_q, press;
    logic [DW-1:0] stab_q [3];
    logic [DW-1:0] stab_d [3];
    logic [7:0]    sel_q, sel_d, sel_inc, sel_dec, sel_auto, cnt_m1;
    logic          auto_q, auto_d, chg_q, chg_d, due;
    logic [HW-1:0] hold_q, hold_d, hold_adv;

    // Two-flop synchroniser: the raw buttons are asynchronous to the pixel clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_mode_i, btn_prev_i, btn_next_i};
            sync2_q <= sync1_q;
        end
    end

    // Stability run per button over frame samples; debounced level follows once the run is long enough
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stab_d[i] = (sync2_q[i] != samp_q[i]) ? '0 : (stab_q[i] == DEB_MAX) ? DEB_MAX : stab_q[i] + 1'b1;
            deb_d[i]  = (stab_d[i] == DEB_MAX) ? sync2_q[i] : deb_q[i];
        end
        press = deb_d & ~deb_q;
    end

    // Debounce state advances on frame boundaries; pending presses are consumed by the next boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            deb_q  <= '0;
            pend_q <= '0;
            stab_q <= '{default: '0};
        end else if (frame_start_i) begin
            samp_q <= sync2_q;
            deb_q  <= deb_d;
            pend_q <= press;
            stab_q <= stab_d;
        end
    end

`ifdef FLAG_SEQ_SHUFFLE_EN
    logic [7:0] lfsr_q;
    logic [8:0] t0, t1;

    // Free-running Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Random forward jump of 1..8, folded back into the table
    always_comb begin
        t0       = {1'b0, sel_q} + {6'd0, lfsr_q[2:0]} + 9'd1;
        t1       = (t0 >= {1'b0, count_i}) ? t0 - {1'b0, count_i} : t0;
        sel_auto = (t1 >= {1'b0, count_i}) ? 8'd0 : t1[7:0];
    end
`else
    assign sel_auto = sel_inc;
`endif

    // Apply pending actions and the slideshow timer at each frame boundary
    always_comb begin
        cnt_m1   = (count_i == 8'd0) ? 8'd0 : count_i - 8'd1;
        sel_inc  = (sel_q == cnt_m1) ? 8'd0 : sel_q + 8'd1;
        sel_dec  = (sel_q == 8'd0) ? cnt_m1 : sel_q - 8'd1;
        due      = auto_q && (hold_q == HOLD_MAX);
        hold_adv = !auto_q ? hold_q : due ? '0 : hold_q + 1'b1;
        sel_d    = sel_q;
        auto_d   = auto_q;
        hold_d   = hold_q;
        chg_d    = 1'b0;
        if (frame_start_i) begin
            auto_d = auto_q ^ pend_q[2];
            hold_d = pend_q[2] ? '0 : hold_adv;
            if (count_i == 8'd0) begin
                sel_d = 8'd0;
            end else if (sel_q >= count_i) begin
                sel_d  = 8'd0;
                hold_d = '0;
            end else if (pend_q[0] && !pend_q[1]) begin
                sel_d  = sel_inc;
                hold_d = '0;
            end else if (pend_q[1] && !pend_q[0]) begin
                sel_d  = sel_dec;
                hold_d = '0;
            end else if (!pend_q[0] && !pend_q[1] && due) begin
                sel_d = sel_auto;
            end
            chg_d = (count_i != 8'd0) && (sel_d != sel_q);
        end
    end

    // Output and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 8'd0;
            auto_q <= 1'b1;
            chg_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            sel_q  <= sel_d;
            auto_q <= auto_d;
            chg_q  <= chg_d;
            hold_q <= hold_d;
        end
    end

    assign selector_o  = sel_q;
    assign auto_mode_o = auto_q;
    assign changed_o   = chg_q;
endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: directed and random stimulus against a frame-level behavioural model
`timescale 1ns/1ps
module tb_flag_sequencer;
    localparam int HOLD = 4;
    localparam int DEB  = 2;

    logic       clk = 0, rst_n = 0, frame_start = 0;
    logic       btn_next = 0, btn_prev = 0, btn_mode = 0;
    logic [7:0] count = 8'd36;
    logic [7:0] selector;
    logic       auto_mode, changed;

    int n_checks = 0, n_errors = 0, chg_seen = 0;

    // model state: frames since hold restart, run length of equal samples per button
    int         msel, mage;
    int         run [3];
    bit         mauto, mchg;
    logic [2:0] mlast, mdeb, mpend;

    flag_sequencer #(.HOLD_FRAMES(HOLD), .DEBOUNCE_FRAMES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start),
        .btn_next_i(btn_next), .btn_prev_i(btn_prev), .btn_mode_i(btn_mode),
        .count_i(count), .selector_o(selector), .auto_mode_o(auto_mode), .changed_o(changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_frame();
        logic [2:0] lvl, prs;
        bit due;
        int old;
        lvl = {btn_mode, btn_prev, btn_next};
        prs = '0;
        for (int b = 0; b < 3; b++) begin
            run[b]   = (lvl[b] == mlast[b]) ? run[b] + 1 : 1;
            mlast[b] = lvl[b];
            if (run[b] >= DEB) begin
                prs[b]  = lvl[b] && !mdeb[b];
                mdeb[b] = lvl[b];
            end
        end
        old = msel;
        due = mauto && (mage % HOLD == HOLD - 1);
        if (mauto) mage++;
        if (count == 0) msel = 0;
        else if (msel >= count) begin msel = 0; mage = 0; end
        else if (mpend[0] && mpend[1]) begin end
        else if (mpend[0]) begin msel = (msel + 1) % count; mage = 0; end
        else if (mpend[1]) begin msel = (msel + count - 1) % count; mage = 0; end
        else if (due) msel = (msel + 1) % count;
        if (mpend[2]) begin mauto = !mauto; mage = 0; end
        mchg  = (count != 0) && (msel != old);
        mpend = prs;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msel = 0; mage = 0; mauto = 1; mchg = 0;
            mlast = '0; mdeb = '0; mpend = '0;
            for (int b = 0; b < 3; b++) run[b] = 1;
        end else begin
            mchg = 0;
            if (frame_start) apply_frame();
        end
    end

    always @(negedge clk) begin
        check("selector", int'(selector), msel);
        check("auto_mode", int'(auto_mode), int'(mauto));
        check("changed", int'(changed), int'(mchg));
        if (changed === 1'b1) chg_seen++;
    end

    task automatic frame(input logic [2:0] b);
        {btn_mode, btn_prev, btn_next} = b;
        repeat ($urandom_range(6, 3)) @(posedge clk);
        #1 frame_start = 1;
        @(posedge clk);
        #1 frame_start = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) frame(3'b000);
    endtask

    task automatic press(input logic [2:0] b);
        frame(b); frame(b); frame(3'b000); frame(3'b000);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("rst_sel", int'(selector), 0);
        check("rst_auto", int'(auto_mode), 1);
        check("rst_chg", int'(changed), 0);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        int c0;
        logic [2:0] rb;
        rb = '0;
        #12;
        check("por_sel", int'(selector), 0);
        check("por_auto", int'(auto_mode), 1);
        @(posedge clk);
        #1 rst_n = 1;
        frames(3);
        check("auto_hold", int'(selector), 0);
        c0 = chg_seen;
        frame(3'b000);
        check("auto_step", int'(selector), 1);
        check("auto_step_pulse", chg_seen - c0, 1);
        frames(140);
        check("auto_wrap", int'(selector), 0);
        frames(4);
        check("auto_again", int'(selector), 1);
        do_reset();
        frames(3);
        check("post_rst_hold", int'(selector), 0);
        frame(3'b000);
        check("post_rst_step", int'(selector), 1);
        do_reset();
        frame(3'b100); frame(3'b100);
        check("mode_wait", int'(auto_mode), 1);
        frame(3'b000);
        check("mode_off", int'(auto_mode), 0);
        c0 = chg_seen;
        frames(20);
        check("manual_sel", int'(selector), 0);
        check("manual_quiet", chg_seen - c0, 0);
        c0 = chg_seen;
        press(3'b010);
        check("prev_wrap", int'(selector), 35);
        check("prev_pulse", chg_seen - c0, 1);
        c0 = chg_seen;
        press(3'b001);
        check("next_wrap", int'(selector), 0);
        check("next_pulse", chg_seen - c0, 1);
        repeat (20) press(3'b001);
        check("next_20", int'(selector), 20);
        count = 8'd10;
        c0 = chg_seen;
        frame(3'b000);
        check("shrink_sel", int'(selector), 0);
        check("shrink_pulse", chg_seen - c0, 1);
        count = 8'd0;
        c0 = chg_seen;
        frames(10);
        check("empty_sel", int'(selector), 0);
        check("empty_quiet", chg_seen - c0, 0);
        count = 8'd36;
        frame(3'b001); frames(3);
        check("glitch_sel", int'(selector), 0);
        c0 = chg_seen;
        press(3'b011);
        check("both_sel", int'(selector), 0);
        check("both_quiet", chg_seen - c0, 0);
        count = 8'd1;
        c0 = chg_seen;
        press(3'b001);
        check("one_sel", int'(selector), 0);
        check("one_quiet", chg_seen - c0, 0);
        count = 8'd36;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) if ($urandom_range(3, 0) == 0) rb[i] = ~rb[i];
            if ($urandom_range(9, 0) == 0) begin
                case ($urandom_range(5, 0))
                    0: count = 8'd0;
                    1: count = 8'd1;
                    2: count = 8'd3;
                    3: count = 8'd36;
                    4: count = 8'd255;
                    default: count = 8'($urandom_range(255, 0));
                endcase
            end
            if (n == 200) do_reset();
            frame(rb);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
